// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory.
// Latency: request sampled in IDLE, memory driven next cycle, ack the cycle after (3-cycle slots).
// Backpressure: requesters hold reqN until ackN; losers wait, one access per 3 cycles.
// Ports: clock/reset_n; per-port req/we/addr/wdata in, ack/err/rdata out;
//        mem_addr/mem_wdata/mem_wmem to the memory, mem_dout back (combinational).
module data_mem_arbiter #(
  parameter int ADDR_BITS = 11
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wmem,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        last_grant;   // port granted most recently
  logic        sel;          // port owning the current access
  logic        we_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;

  logic        win;
  logic [31:0] win_addr;
  logic        win_err;

  // A tie goes to the port that did not win last time.
  assign win      = (req0 && req1) ? ~last_grant : req1;
  assign win_addr = win ? addr1 : addr0;
  // Reject misaligned words and anything beyond the attached memory.
  assign win_err  = (win_addr[1:0] != 2'b00) || (win_addr[31:ADDR_BITS+2] != '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wmem  = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    err0      = 1'b0;
    err1      = 1'b0;
    rdata0    = '0;
    rdata1    = '0;
    case (state)
      IDLE: begin
        if (req0 || req1) state_nxt = ACCESS;
      end
      ACCESS: begin
        // Write commits on the edge leaving ACCESS; rejected accesses never write.
        mem_wmem  = we_q & ~err_q;
        state_nxt = RESP;
      end
      RESP: begin
        if (sel) begin
          ack1   = 1'b1;
          err1   = err_q;
          rdata1 = rdata_q;
        end else begin
          ack0   = 1'b1;
          err0   = err_q;
          rdata0 = rdata_q;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;  // port 0 wins the first tie
      sel        <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      if (state == IDLE && (req0 || req1)) begin
        last_grant <= win;
        sel        <= win;
        we_q       <= win ? we1 : we0;
        addr_q     <= win_addr;
        wdata_q    <= win ? wdata1 : wdata0;
        err_q      <= win_err;
      end
      if (state == ACCESS) begin
        rdata_q <= (!we_q && !err_q) ? mem_dout : '0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus random two-port traffic,
// every cycle compared against a transaction-level model with its own memory copy.
// The attached memory is an environment array, separate from the model's.
module tb_data_mem_arbiter;

  localparam int AB    = 11;
  localparam int WORDS = 1 << AB;

  logic        clock, reset_n;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_dout;
  logic        mem_wmem;

  data_mem_arbiter #(.ADDR_BITS(AB)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmem(mem_wmem),
    .mem_dout(mem_dout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // attached memory
  logic [31:0] mem [0:WORDS-1];
  assign mem_dout = mem[mem_addr[AB+1:2]];
  always @(posedge clock) if (mem_wmem) mem[mem_addr[AB+1:2]] <= mem_wdata;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] refmem [0:WORDS-1];
  int          m_busy;     // cycles left in current 3-cycle slot after grant
  int          m_last, m_port;
  bit          m_we, m_err;
  logic [31:0] m_addr, m_wdata;
  logic        e_ack0, e_ack1, e_err0, e_err1, e_wmem;
  logic [31:0] e_rd0, e_rd1, e_maddr, e_mwd;

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'(4 * WORDS));
  endfunction

  task automatic model_reset();
    m_busy = 0; m_last = 1; m_port = 0;
    e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0; e_wmem = 0;
    e_rd0 = 0; e_rd1 = 0; e_maddr = 0; e_mwd = 0;
  endtask

  task automatic model_step();
    logic [31:0] rv;
    e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0; e_wmem = 0;
    e_rd0 = 0; e_rd1 = 0;
    if (m_busy == 0) begin
      if (req0 || req1) begin
        m_port  = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
        m_last  = m_port;
        m_we    = (m_port == 1) ? we1 : we0;
        m_addr  = (m_port == 1) ? addr1 : addr0;
        m_wdata = (m_port == 1) ? wdata1 : wdata0;
        m_err   = bad_addr(m_addr);
        e_maddr = m_addr;
        e_mwd   = m_wdata;
        e_wmem  = m_we && !m_err;
        m_busy  = 2;
      end
    end else if (m_busy == 2) begin
      rv = (m_we || m_err) ? 32'h0 : refmem[int'(m_addr >> 2)];
      if (m_we && !m_err) refmem[int'(m_addr >> 2)] = m_wdata;
      if (m_port == 1) begin e_ack1 = 1; e_err1 = m_err; e_rd1 = rv; end
      else             begin e_ack0 = 1; e_err0 = m_err; e_rd0 = rv; end
      m_busy = 1;
    end else begin
      m_busy = 0;
    end
  endtask

  task automatic check_outputs();
    chk("ack0", 32'(ack0), 32'(e_ack0));
    chk("ack1", 32'(ack1), 32'(e_ack1));
    chk("err0", 32'(err0), 32'(e_err0));
    chk("err1", 32'(err1), 32'(e_err1));
    chk("rdata0", rdata0, e_rd0);
    chk("rdata1", rdata1, e_rd1);
    chk("mem_wmem", 32'(mem_wmem), 32'(e_wmem));
    chk("mem_addr", mem_addr, e_maddr);
    chk("mem_wdata", mem_wdata, e_mwd);
  endtask

  // One clock: model samples inputs at the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clock);
    model_step();
    @(negedge clock);
    cyc++;
    check_outputs();
  endtask

  task automatic set_port(input int p, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    model_reset();
    #1 check_outputs();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic run_req(input int p, input bit w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic er);
    bit got = 0;
    rd = 0; er = 0;
    set_port(p, 1, w, a, d);
    for (int i = 0; i < 12 && !got; i++) begin
      step();
      if ((p == 0 && ack0) || (p == 1 && ack1)) begin
        got = 1;
        rd  = (p == 1) ? rdata1 : rdata0;
        er  = (p == 1) ? err1 : err0;
      end
    end
    set_port(p, 0, 0, 0, 0);
    chk("acked", 32'(got), 32'd1);
  endtask

  function automatic logic [31:0] rand_addr();
    int k = $urandom_range(0, 9);
    if (k == 0) return {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
    if (k == 1) return ($urandom | 32'h0000_2000) & 32'hFFFF_FFFC;
    return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  logic [31:0] rd;
  logic        er;
  int          ack_cyc[$];
  int          ack_port[$];
  bit          pend[2];
  int          n0;

  initial begin
    reset_n = 1'b0;
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    for (int i = 0; i < WORDS; i++) begin
      mem[i]    = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
      refmem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
    end
    model_reset();
    #23;
    check_outputs();
    @(negedge clock);
    reset_n = 1'b1;

    // single write then read
    run_req(0, 1, 32'h10, 32'hDEADBEEF, rd, er);
    chk("wr10_err", 32'(er), 32'd0);
    run_req(0, 0, 32'h10, 32'h0, rd, er);
    chk("rd10_data", rd, 32'hDEADBEEF);
    chk("rd10_err", 32'(er), 32'd0);

    // ties from reset: port 0 first, port 1 three cycles later; twice
    do_reset();
    for (int t = 0; t < 2; t++) begin
      ack_cyc.delete(); ack_port.delete();
      set_port(0, 1, 1, 32'h30, 32'h3030_0000 + 32'(t));
      set_port(1, 1, 1, 32'h34, 32'h3434_0000 + 32'(t));
      for (int i = 0; i < 12 && (req0 || req1); i++) begin
        step();
        if (ack0) begin set_port(0, 0, 0, 0, 0); ack_cyc.push_back(cyc); ack_port.push_back(0); end
        if (ack1) begin set_port(1, 0, 0, 0, 0); ack_cyc.push_back(cyc); ack_port.push_back(1); end
      end
      chk("tie_nacks", 32'(ack_port.size()), 32'd2);
      if (ack_port.size() == 2) begin
        chk("tie_first", 32'(ack_port[0]), 32'd0);
        chk("tie_second", 32'(ack_port[1]), 32'd1);
        chk("tie_gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
      end
      step();
    end

    // misaligned write on port 1
    run_req(1, 1, 32'h6, 32'h1234_5678, rd, er);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_rdata", rd, 32'd0);

    // out-of-range read on port 0
    run_req(0, 0, 32'h2000, 32'h0, rd, er);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_rdata", rd, 32'd0);

    // req1 held continuously, req0 joins mid-stream
    n0 = 0;
    set_port(1, 1, 0, 32'h10, 32'h0);
    for (int i = 0; i < 15; i++) begin
      if (i == 4) set_port(0, 1, 0, 32'h14, 32'h0);
      step();
      if (ack0) begin set_port(0, 0, 0, 0, 0); n0++; end
    end
    set_port(1, 0, 0, 0, 0);
    chk("b2b_ack0", 32'(n0), 32'd1);
    for (int i = 0; i < 3; i++) step();

    // reset in the middle of a write
    run_req(0, 1, 32'h20, 32'h1111_1111, rd, er);
    set_port(0, 1, 1, 32'h20, 32'h2222_2222);
    for (int i = 0; i < 6 && !e_wmem; i++) step();
    chk("pre_rst_wmem", 32'(mem_wmem), 32'd1);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_wmem", 32'(mem_wmem), 32'd0);
    check_outputs();
    set_port(0, 0, 0, 0, 0);
    @(negedge clock);
    check_outputs();
    reset_n = 1'b1;
    run_req(0, 0, 32'h20, 32'h0, rd, er);
    chk("rst_old_val", rd, 32'h1111_1111);

    // random two-port traffic
    pend[0] = 0; pend[1] = 0;
    for (int c = 0; c < 600; c++) begin
      step();
      if (ack0) begin pend[0] = 0; set_port(0, 0, 0, 0, 0); end
      if (ack1) begin pend[1] = 0; set_port(1, 0, 0, 0, 0); end
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1;
          set_port(p, 1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
      end
    end
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 11, the word-address width of the attached data memory (2048 words).
REQ-002 Port: clock  input  1  single clock; memory writes commit on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Ports: req0 / req1  input  1  access request from port 0 (CPU load/store) / port 1 (debug/DMA); held until ackN.
REQ-005 Ports: we0 / we1  input  1  1 = write, 0 = read; stable while reqN high.
REQ-006 Ports: addr0 / addr1  input  32  byte address; stable while reqN high.
REQ-007 Ports: wdata0 / wdata1  input  32  write data; stable while reqN high.
REQ-008 Ports: ack0 / ack1  output  1  one-cycle completion pulse.
REQ-009 Ports: err0 / err1  output  1  valid with ackN; access rejected.
REQ-010 Ports: rdata0 / rdata1  output  32  read data, valid with ackN.
REQ-011 Port: mem_addr  output  32  address to the data memory.
REQ-012 Port: mem_wdata  output  32  write data to the data memory.
REQ-013 Port: mem_wmem  output  1  memory write enable.
REQ-014 Port: mem_dout  input  32  combinational read data from the data memory.

Function
REQ-015 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-016 IDLE: if neither req is high, the FSM SHALL stay in IDLE.
REQ-017 IDLE: if any req is high, the FSM SHALL pick a winner, latch its port, we, addr and wdata, compute err, and go to ACCESS.
REQ-018 Arbitration SHALL be round-robin: with both reqs high, the port not granted last wins; with one req high, that port wins; the last-grant pointer updates on every grant.
REQ-019 err SHALL be 1 when addr[1:0] != 0 or addr[31:ADDR_BITS+2] != 0.
REQ-020 ACCESS: mem_addr SHALL equal the latched addr.
REQ-021 ACCESS: mem_wdata SHALL equal the latched wdata.
REQ-022 ACCESS: mem_wmem SHALL equal latched we AND NOT err, so the write commits on the edge leaving ACCESS.
REQ-023 ACCESS: on reads without err, mem_dout SHALL be captured into the rdata register; on err or writes, the rdata register SHALL be loaded with 0.
REQ-024 After ACCESS the FSM SHALL go unconditionally to RESP.
REQ-025 RESP: ackN of the granted port SHALL be 1 for exactly one cycle, with rdataN and errN valid; the other port's ack, err and rdata SHALL be 0.
REQ-026 After RESP the FSM SHALL go to IDLE; a request already pending is granted in that IDLE cycle.
REQ-027 Latency SHALL be fixed: request sampled in IDLE at edge T, memory driven in cycle T+1, ack in cycle T+2; at most one access per 3 cycles.
REQ-028 mem_wmem SHALL be 0 in IDLE and RESP.
REQ-029 mem_addr and mem_wdata SHALL hold the last latched values outside ACCESS.
REQ-030 reqN changes during ACCESS or RESP SHALL be ignored until the next IDLE.
REQ-031 A requester that keeps reqN high after ackN SHALL be treated as a new request.

Reset
REQ-032 On reset_n low, the block SHALL asynchronously enter IDLE.
REQ-033 On reset_n low, all outputs SHALL go to 0, including mem_wmem, with no wait for a clock edge.
REQ-034 On reset_n low, all latched registers SHALL clear and the last-grant pointer SHALL be set to port 1, so port 0 wins the first tie.
REQ-035 A reset during ACCESS SHALL suppress the write and produce no ack; the interrupted request is lost.
REQ-036 Operation SHALL resume on the first rising clock edge after reset_n goes high.

Verification
REQ-037 Single write then read: port 0 write addr 0x0000_0010, data 0xDEADBEEF -> mem_wmem=1 for one cycle with mem_addr 0x10, ack0 2 cycles after grant; port 0 read of 0x10 -> rdata0=0xDEADBEEF, err0=0.
REQ-038 Simultaneous requests from reset: req0 and req1 high in the same cycle -> port 0 acked first, port 1 acked 3 cycles later; a second tie goes to port 0 after a port 1 grant.
REQ-039 Misaligned write: port 1 write to 0x0000_0006 -> mem_wmem stays 0, ack1=1, err1=1, rdata1=0.
REQ-040 Out-of-range read: port 0 read of 0x0000_2000 (ADDR_BITS=11) -> ack0=1, err0=1, rdata0=0.
REQ-041 Back-to-back requests: req1 held continuously -> one ack1 every 3 cycles; req0 asserted mid-stream is granted at the next IDLE.
REQ-042 Reset mid-access: reset_n low during ACCESS of a write to 0x20 -> mem_wmem drops immediately, no ack, and a later read of 0x20 returns the old value.
